// File: rtl/fpu_pkg.sv
// Shared FPU dispatch types: opcode encoding, request record and datapath widths.
package fpu_pkg;

    localparam int unsigned FPU_WIDTH = 32;
    localparam int unsigned FPU_RES_W = 24;
    localparam int unsigned FPU_TAG_W = 4;

    typedef enum logic [2:0] {
        ADD     = 3'b000,
        SUB     = 3'b001,
        MUL     = 3'b010,
        MAX     = 3'b011,
        MIN     = 3'b100,
        ABS     = 3'b101,
        NEG     = 3'b110,
        ILLEGAL = 3'b111
    } fpu_op_e;

    typedef struct packed {
        logic [FPU_WIDTH-1:0] a;
        logic [FPU_WIDTH-1:0] b;
        fpu_op_e              op;
        logic [FPU_TAG_W-1:0] tag;
    } fpu_req_t;

    function automatic logic is_illegal(input fpu_op_e op);
        return op == ILLEGAL;
    endfunction

endpackage

// File: rtl/fpu_dispatch_fifo.sv
// Generic synchronous FIFO for dispatch requests. DEPTH must be a power of two so the
// pointers wrap naturally; the occupancy count is one bit wider than the pointers.
module fpu_dispatch_fifo
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter type         data_t = fpu_req_t
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  data_t                  wdata_i,
    input  logic                   pop_i,
    output data_t                  rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    data_t           mem_q [DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // No push-through when full, even if a pop happens in the same cycle.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + PtrW'(1);
        if (do_pop)  rptr_d = rptr_q + PtrW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fpu_dispatch.sv
// Issue stage in front of the combinational FPU: request FIFO, single issue slot and a
// valid/ready response register. Define FPU_DISPATCH_STATS_EN to add capture/stall counters.
module fpu_dispatch
    import fpu_pkg::*;
#(
    parameter int unsigned WIDTH = FPU_WIDTH,
    parameter int unsigned RES_W = FPU_RES_W,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = FPU_TAG_W
) (
    input  logic             core_clock_i,
    input  logic             core_reset_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] req_a_i,
    input  logic [WIDTH-1:0] req_b_i,
    input  logic [2:0]       req_op_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic [WIDTH-1:0] fpu_a_o,
    output logic [WIDTH-1:0] fpu_b_o,
    output logic [2:0]       fpu_ctrl_o,
    input  logic [RES_W-1:0] fpu_res_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [RES_W-1:0] rsp_res_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             rsp_err_o,
`ifdef FPU_DISPATCH_STATS_EN
    output logic [31:0]      stat_issued_o,
    output logic [31:0]      stat_stall_o,
`endif
    output logic             busy_o
);

    typedef enum logic {StEmpty, StFull} slot_state_e;

    fpu_req_t               req_w, fifo_head;
    logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;

    slot_state_e      state_q, state_d;
    fpu_req_t         issue_q, issue_d;
    logic             capture;

    logic             rsp_valid_q, rsp_valid_d;
    logic [RES_W-1:0] rsp_res_q, rsp_res_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic             rsp_err_q, rsp_err_d;

    assign req_w = '{a: req_a_i, b: req_b_i, op: fpu_op_e'(req_op_i), tag: req_tag_i};

    // Ready is held low while reset is asserted so every output reads 0 during reset.
    assign req_ready_o = ~core_reset_i & ~fifo_full;
    assign fifo_push   = req_valid_i & req_ready_o;

    fpu_dispatch_fifo #(
        .DEPTH  (DEPTH),
        .data_t (fpu_req_t)
    ) u_fifo (
        .clk_i   (core_clock_i),
        .rst_i   (core_reset_i),
        .push_i  (fifo_push),
        .wdata_i (req_w),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign capture = (state_q == StFull) & (~rsp_valid_q | rsp_ready_i);

    always_comb begin
        state_d  = state_q;
        issue_d  = issue_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            StEmpty: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    issue_d  = fifo_head;
                    state_d  = StFull;
                end
            end
            StFull: begin
                if (capture) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        issue_d  = fifo_head;
                    end else begin
                        state_d = StEmpty;
                    end
                end
            end
        endcase
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_res_d   = rsp_res_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_err_d   = rsp_err_q;
        if (capture) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = is_illegal(issue_q.op);
            rsp_res_d   = is_illegal(issue_q.op) ? '0 : fpu_res_i;
            rsp_tag_d   = issue_q.tag;
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge core_clock_i or posedge core_reset_i) begin
        if (core_reset_i) begin
            state_q     <= StEmpty;
            issue_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_res_q   <= '0;
            rsp_tag_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_q     <= issue_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign fpu_a_o     = (state_q == StFull) ? issue_q.a  : '0;
    assign fpu_b_o     = (state_q == StFull) ? issue_q.b  : '0;
    assign fpu_ctrl_o  = (state_q == StFull) ? issue_q.op : 3'b000;

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_res_o   = rsp_res_q;
    assign rsp_tag_o   = rsp_tag_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = (fifo_count != '0) | (state_q == StFull) | rsp_valid_q;

`ifdef FPU_DISPATCH_STATS_EN
    logic [31:0] stat_issued_q, stat_issued_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    always_comb begin
        stat_issued_d = stat_issued_q;
        stat_stall_d  = stat_stall_q;
        if (capture && stat_issued_q != '1)                      stat_issued_d = stat_issued_q + 32'd1;
        if (rsp_valid_q && !rsp_ready_i && stat_stall_q != '1) stat_stall_d  = stat_stall_q + 32'd1;
    end

    always_ff @(posedge core_clock_i or posedge core_reset_i) begin
        if (core_reset_i) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_issued_o = stat_issued_q;
    assign stat_stall_o  = stat_stall_q;
`endif

endmodule

// File: tb/tb_fpu_dispatch.sv
// Randomised self-checking bench for fpu_dispatch with a stand-in FPU and an in-order
// scoreboard of expected responses.
module tb_fpu_dispatch;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned RES_W = 24;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;

    typedef struct packed {
        logic             err;
        logic [TAG_W-1:0] tag;
        logic [RES_W-1:0] res;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, req_ready;
    logic [WIDTH-1:0] req_a, req_b;
    logic [2:0]       req_op;
    logic [TAG_W-1:0] req_tag;
    logic [WIDTH-1:0] fpu_a, fpu_b;
    logic [2:0]       fpu_ctrl;
    logic [RES_W-1:0] fpu_res;
    logic             rsp_valid, rsp_ready, rsp_err, busy;
    logic [RES_W-1:0] rsp_res;
    logic [TAG_W-1:0] rsp_tag;
`ifdef FPU_DISPATCH_STATS_EN
    logic [31:0]      stat_issued, stat_stall;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pushed = 0;
    int   n_rsp    = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    // Stand-in for the combinational FPU: plain integer arithmetic, truncated to RES_W.
    function automatic logic [RES_W-1:0] fpu_model(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic [2:0] op);
        logic [WIDTH-1:0] r;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a * b;
            3'd3:    r = (a > b) ? a : b;
            3'd4:    r = (a < b) ? a : b;
            3'd5:    r = a[WIDTH-1] ? -a : a;
            3'd6:    r = -a;
            default: r = 32'hdead_beef;
        endcase
        return r[RES_W-1:0];
    endfunction

    assign fpu_res = fpu_model(fpu_a, fpu_b, fpu_ctrl);

    fpu_dispatch #(
        .WIDTH (WIDTH),
        .RES_W (RES_W),
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .core_clock_i  (clk),
        .core_reset_i  (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_a_i       (req_a),
        .req_b_i       (req_b),
        .req_op_i      (req_op),
        .req_tag_i     (req_tag),
        .fpu_a_o       (fpu_a),
        .fpu_b_o       (fpu_b),
        .fpu_ctrl_o    (fpu_ctrl),
        .fpu_res_i     (fpu_res),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_res_o     (rsp_res),
        .rsp_tag_o     (rsp_tag),
        .rsp_err_o     (rsp_err),
`ifdef FPU_DISPATCH_STATS_EN
        .stat_issued_o (stat_issued),
        .stat_stall_o  (stat_stall),
`endif
        .busy_o        (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [2:0] op, input logic [TAG_W-1:0] tag);
        req_valid = v;
        req_a     = $urandom;
        req_b     = $urandom;
        req_op    = op;
        req_tag   = tag;
    endtask

    // Record each accepted request as an expected response.
    always @(negedge clk) begin
        if (!rst && req_valid && req_ready) begin
            exp_t e;
            e.err = (req_op == 3'b111);
            e.tag = req_tag;
            e.res = e.err ? '0 : fpu_model(req_a, req_b, req_op);
            exp_q.push_back(e);
            n_pushed++;
        end
    end

    // In-order scoreboard plus stability of a stalled response.
    logic             held_v = 1'b0;
    logic [RES_W-1:0] held_res;
    logic [TAG_W-1:0] held_tag;
    logic             held_err;

    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
            n_rsp  = 0;
        end else begin
            if (held_v) begin
                check_eq("hold_valid", rsp_valid, 1'b1);
                check_eq("hold_data", {rsp_err, rsp_tag, rsp_res}, {held_err, held_tag, held_res});
            end
            if (rsp_valid && rsp_ready) begin
                n_rsp++;
                if (exp_q.size() == 0) begin
                    check_eq("rsp_spurious", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("rsp_tag", rsp_tag, e.tag);
                    check_eq("rsp_res", rsp_res, e.res);
                    check_eq("rsp_err", rsp_err, e.err);
                end
            end
            held_v   = rsp_valid && !rsp_ready;
            held_res = rsp_res;
            held_tag = rsp_tag;
            held_err = rsp_err;
        end
    end

    initial begin
        logic [WIDTH-1:0] a0, b0;
        int               cyc;

        // Reset with a request pending.
        rst       = 1'b1;
        rsp_ready = 1'b1;
        set_req(1'b1, 3'b000, 4'd1);
        repeat (3) step();
        @(negedge clk);
        check_eq("rst_outputs", {req_ready, fpu_a, fpu_b, fpu_ctrl, rsp_valid},
                 '0);
        check_eq("rst_rsp", {rsp_res, rsp_tag, rsp_err, busy}, '0);
        step();
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", req_ready, 1'b1);
        check_eq("idle_after_rst", {busy, rsp_valid}, 2'b00);
        step();

        // Single ADD, tag 3: issue one edge after accept, response one edge later.
        set_req(1'b1, 3'b000, 4'd3);
        a0 = req_a;
        b0 = req_b;
        step();
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("single_slot_empty", {fpu_a, rsp_valid}, '0);
        step();
        @(negedge clk);
        check_eq("single_issue_a", fpu_a, a0);
        check_eq("single_issue_b", fpu_b, b0);
        check_eq("single_issue_ctrl", fpu_ctrl, 3'b000);
        check_eq("single_no_rsp_yet", rsp_valid, 1'b0);
        step();
        @(negedge clk);
        check_eq("single_rsp_valid", rsp_valid, 1'b1);
        check_eq("single_rsp_tag", rsp_tag, 4'd3);
        check_eq("single_rsp_err", rsp_err, 1'b0);
        check_eq("single_rsp_res", rsp_res, fpu_model(a0, b0, 3'b000));
        step();
        step();

        // Fill under backpressure: 4 in FIFO, 1 issued, 1 in response register.
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_req(1'b1, 3'($urandom_range(0, 6)), TAG_W'(i));
            @(negedge clk);
            check_eq("fill_ready", req_ready, 1'b1);
            step();
        end
        set_req(1'b1, 3'b001, 4'd6);
        repeat (3) begin
            @(negedge clk);
            check_eq("full_ready_low", req_ready, 1'b0);
            check_eq("full_rsp_head", {rsp_valid, rsp_tag}, {1'b1, 4'd0});
            check_eq("full_busy", busy, 1'b1);
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("drain_order", {rsp_valid, rsp_tag}, {1'b1, TAG_W'(i)});
        end
        step();
        repeat (3) step();
        check_eq("drain_queue_empty", 32'(exp_q.size()), 32'd0);

        // Illegal op between two legal neighbours.
        set_req(1'b1, 3'b000, 4'd8);
        step();
        set_req(1'b1, 3'b111, 4'd9);
        step();
        set_req(1'b1, 3'b001, 4'd10);
        step();
        req_valid = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (!(rsp_valid && rsp_tag == 4'd9) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("illegal_seen", cyc < 20, 1'b1);
        check_eq("illegal_rsp", {rsp_err, rsp_res}, {1'b1, 24'd0});
        repeat (5) step();

        // Random stream with random backpressure.
        n_pushed = 0;
        cyc      = 0;
        while (n_pushed < 100 && cyc < 3000) begin
            set_req($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), TAG_W'($urandom));
            rsp_ready = $urandom_range(0, 3) != 0;
            step();
            cyc++;
        end
        check_eq("stream_pushed", 32'(n_pushed), 32'd100);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        cyc       = 0;
        while ((exp_q.size() != 0 || busy) && cyc < 50) begin
            step();
            cyc++;
        end
        @(negedge clk);
        check_eq("stream_drained", 32'(exp_q.size()), 32'd0);
        check_eq("stream_idle", busy, 1'b0);
`ifdef FPU_DISPATCH_STATS_EN
        check_eq("stat_issued", stat_issued, 64'(n_rsp));
`endif
        step();

        // Reset with three ops in flight discards them all.
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, 3'b010, TAG_W'(i + 12));
            step();
        end
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("inflight_busy", busy, 1'b1);
        step();
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_eq("midrst_outputs", {busy, rsp_valid, req_ready, fpu_ctrl}, '0);
        step();
        rst       = 1'b0;
        rsp_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check_eq("postrst_no_rsp", rsp_valid, 1'b0);
            step();
        end
        check_eq("postrst_idle", busy, 1'b0);
        check_eq("postrst_ready", req_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
